// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
// Bit timing comes from an external oversample enable, OSR ticks per bit.
module uart_tx #(
    parameter int OSR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       BC,
    output logic       tx,
    output logic       tx_busy
);

    localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OSR / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    data_reg, data_nxt;
    logic [1:0]    wls_reg, wls_nxt;
    logic          stb_reg, stb_nxt;
    logic          pen_reg, pen_nxt;
    logic          par_reg, par_nxt;
    logic          line_nxt;

    logic          tick_end;
    logic          stop_end;
    logic [2:0]    last_bit;

    // EPS=1 gives even parity: the data bits plus the parity bit carry an even 1-count.
    function automatic logic parity_of(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - wls);
        return eps ? ^(data & mask) : ~^(data & mask);
    endfunction

    assign tick_end = baud_tick && (tick_cnt == TICK_LAST);
    assign last_bit = 3'd4 + {1'b0, wls_reg};

    // Stop length: 1 bit, 2 bits, or 1.5 bits for 5-bit words (second bit cut at half period).
    always_comb begin
        stop_end = tick_end;
        if (stb_reg) begin
            if (wls_reg == 2'b00)
                stop_end = baud_tick && (bit_cnt == 3'd1) && (tick_cnt == TICK_HALF);
            else
                stop_end = tick_end && (bit_cnt == 3'd1);
        end
    end

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        data_nxt  = data_reg;
        wls_nxt   = wls_reg;
        stb_nxt   = stb_reg;
        pen_nxt   = pen_reg;
        par_nxt   = par_reg;

        if (state != IDLE && baud_tick)
            tick_nxt = tick_end ? '0 : tick_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                    bit_nxt   = 3'd0;
                    data_nxt  = tx_data;
                    wls_nxt   = WLS;
                    stb_nxt   = STB;
                    pen_nxt   = PEN;
                    par_nxt   = parity_of(tx_data, WLS, EPS);
                end
            end
            START: begin
                if (tick_end) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (tick_end) begin
                    if (bit_cnt == last_bit) begin
                        state_nxt = pen_reg ? PARITY : STOP;
                        bit_nxt   = 3'd0;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_nxt = STOP;
                    bit_nxt   = 3'd0;
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_nxt = IDLE;
                    tick_nxt  = '0;
                    bit_nxt   = 3'd0;
                end else if (tick_end) begin
                    bit_nxt = bit_cnt + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tick_nxt  = '0;
                bit_nxt   = 3'd0;
            end
        endcase
    end

    // Line level for the upcoming state, so the registered tx lines up with the state register.
    always_comb begin
        line_nxt = 1'b1;
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = data_nxt[bit_nxt];
            PARITY:  line_nxt = par_nxt;
            default: line_nxt = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            data_reg <= 8'h00;
            wls_reg  <= 2'b00;
            stb_reg  <= 1'b0;
            pen_reg  <= 1'b0;
            par_reg  <= 1'b0;
            tx       <= !BC;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            data_reg <= data_nxt;
            wls_reg  <= wls_nxt;
            stb_reg  <= stb_nxt;
            pen_reg  <= pen_nxt;
            par_reg  <= par_nxt;
            tx       <= !BC && line_nxt;
        end
    end

    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: every frame is compared cycle by cycle against a
// hand-computed line pattern (start + data + parity, LSB first) and stop length.
module tb_uart_tx;

    localparam int OSR = 16;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       BC;
    logic       tx;
    logic       tx_busy;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx #(.OSR(OSR)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .WLS      (WLS),
        .STB      (STB),
        .PEN      (PEN),
        .EPS      (EPS),
        .BC       (BC),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Offer one character at the current negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] data, input logic [1:0] wls, input logic stb,
                        input logic pen, input logic eps, input logic keep_valid);
        tx_data   = data;
        WLS       = wls;
        STB       = stb;
        PEN       = pen;
        EPS       = eps;
        baud_tick = 1'b1;
        tx_valid  = 1'b1;
        check("ready_before_send", tx_ready, 1'b1);
        @(negedge clk);
        if (!keep_valid) begin
            tx_valid = 1'b0;
            tx_data  = ~data;
            WLS      = ~wls;
            STB      = ~stb;
            PEN      = ~pen;
            EPS      = ~eps;
        end
    endtask

    // Follow a frame from the first cycle after acceptance. Ticks arrive every div clocks;
    // BC is held high for cycles [bc_on, bc_off) of the frame.
    task automatic watch(input string tag, input logic [11:0] pat, input int nbits,
                         input int stop_ticks, input int div, input int bc_on, input int bc_off);
        int   bit_len;
        int   total;
        logic exp_line;
        bit_len = OSR * div;
        total   = nbits * bit_len + stop_ticks * div;
        for (int c = 0; c < total; c++) begin
            exp_line = (c < nbits * bit_len) ? pat[c / bit_len] : 1'b1;
            if (c >= bc_on && c < bc_off) exp_line = 1'b0;
            check($sformatf("%s tx c%0d", tag, c), tx, exp_line);
            if (c == 0) begin
                check($sformatf("%s busy", tag), tx_busy, 1'b1);
                check($sformatf("%s not_ready", tag), tx_ready, 1'b0);
            end
            baud_tick = ((c + 1) % div == 0);
            if (c == bc_on - 1) BC = 1'b1;
            if (c == bc_off - 1) BC = 1'b0;
            @(negedge clk);
        end
        check($sformatf("%s ready_end", tag), tx_ready, 1'b1);
        check($sformatf("%s idle_line", tag), tx, 1'b1);
        baud_tick = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        WLS       = 2'b00;
        STB       = 1'b0;
        PEN       = 1'b0;
        EPS       = 1'b0;
        BC        = 1'b0;
        baud_tick = 1'b1;

        // Reset state, and break still forcing the line during reset
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        BC = 1'b1;
        @(negedge clk);
        check("rst_bc_tx", tx, 1'b0);
        BC = 1'b0;
        @(negedge clk);
        check("rst_bc_release", tx, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 0x55, 8N1, tick every clock: 160 clocks
        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        watch("f55", 12'h0AA, 9, 16, 1, -1, -1);

        // 0xF3, 5 bits, even parity -> 1,1,0,0,1 then parity 1
        send(8'hF3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        watch("f5e", 12'h066, 7, 16, 1, -1, -1);

        // Same word, odd parity -> parity 0
        send(8'hF3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        watch("f5o", 12'h026, 7, 16, 1, -1, -1);

        // 5 bits with two stop bits -> 1.5 stop bits (24 ticks); upper data bits ignored
        send(8'hE0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        watch("f5s15", 12'h000, 6, 24, 1, -1, -1);

        // 7 bits with two stop bits -> 32 ticks; bit 7 of 0xFF not sent
        send(8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        watch("f7s2", 12'h0FE, 8, 32, 1, -1, -1);

        // Back-to-back with tx_valid held; data changed after the first acceptance
        send(8'h41, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        tx_data = 8'h42;
        watch("b2b_a", 12'h082, 9, 16, 1, -1, -1);
        @(negedge clk);
        tx_valid = 1'b0;
        watch("b2b_b", 12'h084, 9, 16, 1, -1, -1);

        // Reset during DATA, no acceptance while reset is high, then an intact frame
        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("pre_rst_data_bit1", tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_ready", tx_ready, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        check("rst_no_accept_tx", tx, 1'b1);
        check("rst_no_accept_ready", tx_ready, 1'b1);
        rst      = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        watch("after_rst", 12'h14A, 9, 16, 1, -1, -1);

        // Break for 20 clocks mid-frame; frame continues underneath
        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        watch("brk", 12'h0AA, 9, 16, 1, 50, 70);

        // Tick every other clock, 8 bits, odd parity: 0x0F -> parity 1
        send(8'h0F, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        watch("div2", 12'h21E, 10, 16, 2, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
